// File: rtl/pac_pkg.sv
// Shared definitions for the Pac-Man sprite draw sequencer:
// directions, sprite geometry, colours, start position and FSM states.
package pac_pkg;

  localparam logic [1:0] DIR_RIGHT = 2'd0;
  localparam logic [1:0] DIR_UP    = 2'd1;
  localparam logic [1:0] DIR_LEFT  = 2'd2;
  localparam logic [1:0] DIR_DOWN  = 2'd3;

  localparam int SPRITE_W    = 5;
  localparam int SPRITE_BITS = 25;

  localparam logic [2:0] PAC_COLOUR = 3'b110;
  localparam logic [2:0] BG_COLOUR  = 3'b000;

  localparam logic [7:0] INIT_X = 8'd78;
  localparam logic [6:0] INIT_Y = 7'd58;

  typedef enum logic [2:0] {
    IDLE,
    ERASE,
    ROTATE,
    SETTLE,
    DRAW,
    CLEAR,
    DONE
  } state_t;

  // Bitmap is stored row-major with row0/col0 in the MSB.
  function automatic logic [4:0] spriteBit(input logic [2:0] row, input logic [2:0] col);
    logic [4:0] idx;
    idx = ({2'b00, row} * 5'd5) + {2'b00, col};
    return 5'(SPRITE_BITS - 1) - idx;
  endfunction

endpackage

// File: rtl/sprite_walker.sv
// Row/column walker over the 5x5 sprite, shared by the erase and draw passes.
module sprite_walker
  import pac_pkg::*;
(
  input  logic       clock,
  input  logic       resetn,
  input  logic       clear,
  input  logic       step,
  output logic [2:0] row,
  output logic [2:0] col,
  output logic       last
);

  logic [2:0] r_row;
  logic [2:0] r_col;

  always_ff @(posedge clock) begin
    if (!resetn || clear) begin
      r_row <= 3'd0;
      r_col <= 3'd0;
    end else if (step) begin
      if (r_col == 3'(SPRITE_W - 1)) begin
        r_col <= 3'd0;
        r_row <= r_row + 3'd1;
      end else begin
        r_col <= r_col + 3'd1;
      end
    end
  end

  assign row  = r_row;
  assign col  = r_col;
  assign last = (r_row == 3'(SPRITE_W - 1)) && (r_col == 3'(SPRITE_W - 1));

endmodule

// File: rtl/pac_draw_ctrl.sv
// Sequencer driving the sprite shifter and framebuffer write port:
// erase old sprite, rotate/animate, draw new sprite, or erase-and-clear on hide.
module pac_draw_ctrl
  import pac_pkg::*;
(
  input  logic                   clock,
  input  logic                   resetn,
  input  logic                   start,
  input  logic                   hide,
  input  logic [7:0]             new_x,
  input  logic [6:0]             new_y,
  input  logic [1:0]             new_dir,
  input  logic [SPRITE_BITS-1:0] sprite,
  output logic                   shift_en,
  output logic                   shift_erase,
  output logic [1:0]             rotation,
  output logic [7:0]             vga_x,
  output logic [6:0]             vga_y,
  output logic [2:0]             vga_colour,
  output logic                   vga_plot,
  output logic                   busy,
  output logic                   done
);

  state_t r_state;
  state_t w_nextState;

  logic       r_hideQ;
  logic [7:0] r_newX;
  logic [6:0] r_newY;
  logic [1:0] r_newDir;
  logic [7:0] r_oldX;
  logic [6:0] r_oldY;

  logic       r_shiftEn;
  logic       r_shiftErase;
  logic [1:0] r_rotation;
  logic [7:0] r_vgaX;
  logic [6:0] r_vgaY;
  logic [2:0] r_vgaColour;
  logic       r_vgaPlot;
  logic       r_busy;
  logic       r_done;

  logic [2:0] w_row;
  logic [2:0] w_col;
  logic       w_last;
  logic       w_walkClear;
  logic       w_walkStep;
  logic       w_req;

  logic       w_plot;
  logic [7:0] w_x;
  logic [6:0] w_y;
  logic [2:0] w_colour;
  logic       w_shiftEn;
  logic       w_shiftErase;
  logic       w_busy;
  logic       w_done;

  sprite_walker u_walker (
    .clock  (clock),
    .resetn (resetn),
    .clear  (w_walkClear),
    .step   (w_walkStep),
    .row    (w_row),
    .col    (w_col),
    .last   (w_last)
  );

  // The registered busy flag still covers the done cycle, so gating on it
  // drops a request that lands while done is showing.
  assign w_req = (start | hide) & ~r_busy;

  always_ff @(posedge clock) begin
    if (!resetn) r_state <= IDLE;
    else         r_state <= w_nextState;
  end

  // Outputs are computed one edge ahead so every port comes straight from a flop;
  // the first erase pixel is therefore issued on the accepting edge.
  always_comb begin
    w_nextState  = r_state;
    w_walkClear  = 1'b0;
    w_walkStep   = 1'b0;
    w_plot       = 1'b0;
    w_x          = r_vgaX;
    w_y          = r_vgaY;
    w_colour     = r_vgaColour;
    w_shiftEn    = 1'b0;
    w_shiftErase = 1'b0;
    w_done       = 1'b0;
    w_busy       = 1'b1;
    case (r_state)
      IDLE: begin
        w_busy = w_req;
        if (w_req) begin
          w_nextState = ERASE;
          w_walkStep  = 1'b1;
          w_plot      = 1'b1;
          w_x         = r_oldX + {5'b00000, w_col};
          w_y         = r_oldY + {4'b0000, w_row};
          w_colour    = BG_COLOUR;
        end else begin
          w_walkClear = 1'b1;
        end
      end
      ERASE: begin
        w_plot   = 1'b1;
        w_x      = r_oldX + {5'b00000, w_col};
        w_y      = r_oldY + {4'b0000, w_row};
        w_colour = BG_COLOUR;
        if (w_last) begin
          w_walkClear = 1'b1;
          w_nextState = r_hideQ ? CLEAR : ROTATE;
        end else begin
          w_walkStep = 1'b1;
        end
      end
      ROTATE: begin
        w_shiftEn   = 1'b1;
        w_walkClear = 1'b1;
        w_nextState = SETTLE;
      end
      SETTLE: begin
        w_walkClear = 1'b1;
        w_nextState = DRAW;
      end
      DRAW: begin
        w_plot   = 1'b1;
        w_x      = r_newX + {5'b00000, w_col};
        w_y      = r_newY + {4'b0000, w_row};
        w_colour = sprite[spriteBit(w_row, w_col)] ? PAC_COLOUR : BG_COLOUR;
        if (w_last) begin
          w_walkClear = 1'b1;
          w_nextState = DONE;
        end else begin
          w_walkStep = 1'b1;
        end
      end
      CLEAR: begin
        w_shiftErase = 1'b1;
        w_walkClear  = 1'b1;
        w_nextState  = DONE;
      end
      DONE: begin
        w_done      = 1'b1;
        w_walkClear = 1'b1;
        w_nextState = IDLE;
      end
      default: begin
        w_walkClear = 1'b1;
        w_nextState = IDLE;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (!resetn) begin
      r_hideQ      <= 1'b0;
      r_newX       <= 8'd0;
      r_newY       <= 7'd0;
      r_newDir     <= DIR_RIGHT;
      r_oldX       <= INIT_X;
      r_oldY       <= INIT_Y;
      r_shiftEn    <= 1'b0;
      r_shiftErase <= 1'b0;
      r_rotation   <= DIR_RIGHT;
      r_vgaX       <= 8'd0;
      r_vgaY       <= 7'd0;
      r_vgaColour  <= BG_COLOUR;
      r_vgaPlot    <= 1'b0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
    end else begin
      r_shiftEn    <= w_shiftEn;
      r_shiftErase <= w_shiftErase;
      r_vgaX       <= w_x;
      r_vgaY       <= w_y;
      r_vgaColour  <= w_colour;
      r_vgaPlot    <= w_plot;
      r_busy       <= w_busy;
      r_done       <= w_done;
      if (r_state == IDLE && w_req) begin
        r_hideQ <= hide;
        if (!hide) begin
          r_newX   <= new_x;
          r_newY   <= new_y;
          r_newDir <= new_dir;
        end
      end
      if (r_state == ROTATE) r_rotation <= r_newDir;
      if (r_state == DRAW && w_last) begin
        r_oldX <= r_newX;
        r_oldY <= r_newY;
      end
    end
  end

  assign shift_en    = r_shiftEn;
  assign shift_erase = r_shiftErase;
  assign rotation    = r_rotation;
  assign vga_x       = r_vgaX;
  assign vga_y       = r_vgaY;
  assign vga_colour  = r_vgaColour;
  assign vga_plot    = r_vgaPlot;
  assign busy        = r_busy;
  assign done        = r_done;

endmodule

// File: tb/tb_pac_draw_ctrl.sv
// Randomized bench for pac_draw_ctrl: each request is captured cycle by cycle
// and compared with the expected plot/pulse trace built from the sprite position model.
module tb_pac_draw_ctrl;

  logic        clock = 1'b0;
  logic        resetn;
  logic        start;
  logic        hide;
  logic [7:0]  new_x;
  logic [6:0]  new_y;
  logic [1:0]  new_dir;
  logic [24:0] sprite;
  logic        shift_en;
  logic        shift_erase;
  logic [1:0]  rotation;
  logic [7:0]  vga_x;
  logic [6:0]  vga_y;
  logic [2:0]  vga_colour;
  logic        vga_plot;
  logic        busy;
  logic        done;

  int checks   = 0;
  int failures = 0;

  // Model of where the sprite currently sits and which way it faces.
  logic [7:0] mOldX;
  logic [6:0] mOldY;
  logic [1:0] mRot;

  int         pCyc[$];
  logic [7:0] pX[$];
  logic [6:0] pY[$];
  logic [2:0] pC[$];
  int         enCyc[$];
  int         erCyc[$];
  int         doneCyc[$];
  int         busyCount;
  bit         capTimeout;
  logic [1:0] capRot;

  always #5 clock = ~clock;

  pac_draw_ctrl dut (
    .clock       (clock),
    .resetn      (resetn),
    .start       (start),
    .hide        (hide),
    .new_x       (new_x),
    .new_y       (new_y),
    .new_dir     (new_dir),
    .sprite      (sprite),
    .shift_en    (shift_en),
    .shift_erase (shift_erase),
    .rotation    (rotation),
    .vga_x       (vga_x),
    .vga_y       (vga_y),
    .vga_colour  (vga_colour),
    .vga_plot    (vga_plot),
    .busy        (busy),
    .done        (done)
  );

  // Called at a negedge: presents one request, then records the trace until busy drops.
  task automatic captureRequest(input logic s, input logic h, input logic [7:0] x,
                                input logic [6:0] y, input logic [1:0] d,
                                input int pulseA, input int pulseB);
    int cyc;
    pCyc.delete(); pX.delete(); pY.delete(); pC.delete();
    enCyc.delete(); erCyc.delete(); doneCyc.delete();
    busyCount  = 0;
    capTimeout = 0;
    start = s; hide = h; new_x = x; new_y = y; new_dir = d;
    @(negedge clock);
    start = 1'b0; hide = 1'b0;
    cyc = 1;
    while (1) begin
      if (vga_plot) begin
        pCyc.push_back(cyc); pX.push_back(vga_x); pY.push_back(vga_y); pC.push_back(vga_colour);
      end
      if (shift_en)    enCyc.push_back(cyc);
      if (shift_erase) erCyc.push_back(cyc);
      if (done)        doneCyc.push_back(cyc);
      if (busy)        busyCount++;
      if (!busy) break;
      if (cyc >= 120) begin capTimeout = 1; break; end
      if (cyc == pulseA || cyc == pulseB) begin
        start = 1'b1; new_x = 8'd140; new_y = 7'd100; new_dir = ~d;
      end else begin
        start = 1'b0;
      end
      @(negedge clock);
      cyc++;
    end
    start  = 1'b0;
    capRot = rotation;
  endtask

  task automatic test_reset();
    resetn = 1'b0; start = 1'b1; hide = 1'b0;
    new_x = 8'd5; new_y = 7'd5; new_dir = 2'd3; sprite = 25'h1FFFFFF;
    repeat (3) @(negedge clock);
    checks++; if (busy !== 1'b0)        begin failures++; $display("[TB] FAIL reset_busy got %b expected 0", busy); end
    checks++; if (done !== 1'b0)        begin failures++; $display("[TB] FAIL reset_done got %b expected 0", done); end
    checks++; if (vga_plot !== 1'b0)    begin failures++; $display("[TB] FAIL reset_plot got %b expected 0", vga_plot); end
    checks++; if (shift_en !== 1'b0)    begin failures++; $display("[TB] FAIL reset_shift_en got %b expected 0", shift_en); end
    checks++; if (shift_erase !== 1'b0) begin failures++; $display("[TB] FAIL reset_shift_erase got %b expected 0", shift_erase); end
    checks++; if (rotation !== 2'd0)    begin failures++; $display("[TB] FAIL reset_rotation got %0d expected 0", rotation); end
    checks++; if (vga_x !== 8'd0)       begin failures++; $display("[TB] FAIL reset_vga_x got %0d expected 0", vga_x); end
    checks++; if (vga_y !== 7'd0)       begin failures++; $display("[TB] FAIL reset_vga_y got %0d expected 0", vga_y); end
    checks++; if (vga_colour !== 3'd0)  begin failures++; $display("[TB] FAIL reset_colour got %0d expected 0", vga_colour); end
    start = 1'b0;
    resetn = 1'b1;
    mOldX = 8'd78; mOldY = 7'd58; mRot = 2'd0;
    @(negedge clock);
  endtask

  task automatic test_move();
    logic [7:0]  tx;
    logic [6:0]  ty;
    logic [1:0]  td;
    logic [25:0] expT[$];
    logic [25:0] got;
    int          enFirst;
    int          doneFirst;
    for (int it = 0; it < 5; it++) begin
      if (it == 0)      begin tx = 8'd10; ty = 7'd20; td = 2'd1; end
      else if (it == 1) begin tx = 8'd30; ty = 7'd40; td = 2'($urandom_range(0, 3)); end
      else begin
        tx = 8'($urandom_range(0, 155)); ty = 7'($urandom_range(0, 115)); td = 2'($urandom_range(0, 3));
      end
      sprite = 25'($urandom);
      expT.delete();
      for (int k = 0; k < 25; k++)
        expT.push_back({8'(k + 1), mOldX + 8'(k % 5), mOldY + 7'(k / 5), 3'b000});
      for (int k = 0; k < 25; k++)
        expT.push_back({8'(k + 28), tx + 8'(k % 5), ty + 7'(k / 5), sprite[24 - k] ? 3'b110 : 3'b000});
      captureRequest(1'b1, 1'b0, tx, ty, td, -1, -1);
      checks++; if (capTimeout !== 1'b0) begin failures++; $display("[TB] FAIL move%0d_timeout busy never dropped", it); end
      checks++; if (pCyc.size() != 50) begin failures++; $display("[TB] FAIL move%0d_plot_count got %0d expected 50", it, pCyc.size()); end
      for (int i = 0; i < pCyc.size() && i < 50; i++) begin
        got = {8'(pCyc[i]), pX[i], pY[i], pC[i]};
        checks++;
        if (got !== expT[i]) begin
          failures++;
          $display("[TB] FAIL move%0d_pixel%0d got cyc %0d (%0d,%0d) c%0d expected cyc %0d (%0d,%0d) c%0d",
                   it, i, got[25:18], got[17:10], got[9:3], got[2:0],
                   expT[i][25:18], expT[i][17:10], expT[i][9:3], expT[i][2:0]);
        end
      end
      enFirst   = (enCyc.size() > 0) ? enCyc[0] : -1;
      doneFirst = (doneCyc.size() > 0) ? doneCyc[0] : -1;
      checks++; if (enCyc.size() != 1)   begin failures++; $display("[TB] FAIL move%0d_shift_en_count got %0d expected 1", it, enCyc.size()); end
      checks++; if (enFirst != 26)       begin failures++; $display("[TB] FAIL move%0d_shift_en_cycle got %0d expected 26", it, enFirst); end
      checks++; if (erCyc.size() != 0)   begin failures++; $display("[TB] FAIL move%0d_shift_erase_count got %0d expected 0", it, erCyc.size()); end
      checks++; if (doneCyc.size() != 1) begin failures++; $display("[TB] FAIL move%0d_done_count got %0d expected 1", it, doneCyc.size()); end
      checks++; if (doneFirst != 53)     begin failures++; $display("[TB] FAIL move%0d_done_cycle got %0d expected 53", it, doneFirst); end
      checks++; if (busyCount != 53)     begin failures++; $display("[TB] FAIL move%0d_busy_cycles got %0d expected 53", it, busyCount); end
      checks++; if (capRot !== td)       begin failures++; $display("[TB] FAIL move%0d_rotation got %0d expected %0d", it, capRot, td); end
      mOldX = tx; mOldY = ty; mRot = td;
    end
  endtask

  task automatic test_sprite_pixels();
    sprite = 25'b0111011111110001111101110;
    captureRequest(1'b1, 1'b0, 8'd0, 7'd0, 2'd0, -1, -1);
    checks++; if (pCyc.size() != 50) begin failures++; $display("[TB] FAIL sprite_plot_count got %0d expected 50", pCyc.size()); end
    if (pCyc.size() >= 50) begin
      checks++;
      if (pX[26] !== 8'd1 || pY[26] !== 7'd0 || pC[26] !== 3'b110) begin
        failures++; $display("[TB] FAIL sprite_px_1_0 got (%0d,%0d) c%0d expected (1,0) c6", pX[26], pY[26], pC[26]);
      end
      checks++;
      if (pX[38] !== 8'd3 || pY[38] !== 7'd2 || pC[38] !== 3'b000) begin
        failures++; $display("[TB] FAIL sprite_px_3_2 got (%0d,%0d) c%0d expected (3,2) c0", pX[38], pY[38], pC[38]);
      end
    end
    mOldX = 8'd0; mOldY = 7'd0; mRot = 2'd0;
  endtask

  task automatic test_hide_and_start();
    int doneFirst;
    int erFirst;
    sprite = 25'($urandom);
    captureRequest(1'b1, 1'b1, 8'd99, 7'd99, ~mRot, -1, -1);
    doneFirst = (doneCyc.size() > 0) ? doneCyc[0] : -1;
    erFirst   = (erCyc.size() > 0) ? erCyc[0] : -1;
    checks++; if (pCyc.size() != 25)   begin failures++; $display("[TB] FAIL hide_plot_count got %0d expected 25", pCyc.size()); end
    for (int i = 0; i < pCyc.size() && i < 25; i++) begin
      checks++;
      if (pCyc[i] != i + 1 || pX[i] !== mOldX + 8'(i % 5) || pY[i] !== mOldY + 7'(i / 5) || pC[i] !== 3'b000) begin
        failures++;
        $display("[TB] FAIL hide_pixel%0d got cyc %0d (%0d,%0d) c%0d expected cyc %0d (%0d,%0d) c0",
                 i, pCyc[i], pX[i], pY[i], pC[i], i + 1, mOldX + 8'(i % 5), mOldY + 7'(i / 5));
      end
    end
    checks++; if (enCyc.size() != 0)   begin failures++; $display("[TB] FAIL hide_shift_en_count got %0d expected 0", enCyc.size()); end
    checks++; if (erCyc.size() != 1)   begin failures++; $display("[TB] FAIL hide_shift_erase_count got %0d expected 1", erCyc.size()); end
    checks++; if (erFirst != 26)       begin failures++; $display("[TB] FAIL hide_shift_erase_cycle got %0d expected 26", erFirst); end
    checks++; if (doneFirst != 27)     begin failures++; $display("[TB] FAIL hide_done_cycle got %0d expected 27", doneFirst); end
    checks++; if (busyCount != 27)     begin failures++; $display("[TB] FAIL hide_busy_cycles got %0d expected 27", busyCount); end
    checks++; if (capRot !== mRot)     begin failures++; $display("[TB] FAIL hide_rotation got %0d expected %0d", capRot, mRot); end
  endtask

  task automatic test_busy_ignored();
    logic [7:0] tx;
    logic [6:0] ty;
    tx = 8'($urandom_range(0, 100));
    ty = 7'($urandom_range(0, 90));
    sprite = 25'($urandom);
    captureRequest(1'b1, 1'b0, tx, ty, 2'd2, 10, 53);
    checks++; if (capTimeout !== 1'b0) begin failures++; $display("[TB] FAIL busy_ign_timeout busy never dropped"); end
    checks++; if (pCyc.size() != 50)   begin failures++; $display("[TB] FAIL busy_ign_plot_count got %0d expected 50", pCyc.size()); end
    checks++; if (doneCyc.size() != 1) begin failures++; $display("[TB] FAIL busy_ign_done_count got %0d expected 1", doneCyc.size()); end
    checks++; if (busyCount != 53)     begin failures++; $display("[TB] FAIL busy_ign_busy_cycles got %0d expected 53", busyCount); end
    if (pCyc.size() >= 50) begin
      checks++;
      if (pX[49] !== tx + 8'd4 || pY[49] !== ty + 7'd4) begin
        failures++; $display("[TB] FAIL busy_ign_last_px got (%0d,%0d) expected (%0d,%0d)", pX[49], pY[49], tx + 8'd4, ty + 7'd4);
      end
    end
    mOldX = tx; mOldY = ty; mRot = 2'd2;
  endtask

  task automatic test_back_to_back();
    logic [7:0] t1x;
    logic [6:0] t1y;
    int         doneFirst;
    t1x = 8'($urandom_range(0, 155));
    t1y = 7'($urandom_range(0, 115));
    sprite = 25'($urandom);
    captureRequest(1'b1, 1'b0, t1x, t1y, 2'd3, -1, -1);
    captureRequest(1'b1, 1'b0, 8'd120, 7'd7, 2'd0, -1, -1);
    doneFirst = (doneCyc.size() > 0) ? doneCyc[0] : -1;
    checks++; if (pCyc.size() != 50) begin failures++; $display("[TB] FAIL b2b_plot_count got %0d expected 50", pCyc.size()); end
    if (pCyc.size() > 0) begin
      checks++;
      if (pCyc[0] != 1 || pX[0] !== t1x || pY[0] !== t1y) begin
        failures++; $display("[TB] FAIL b2b_first_erase got cyc %0d (%0d,%0d) expected cyc 1 (%0d,%0d)", pCyc[0], pX[0], pY[0], t1x, t1y);
      end
    end
    checks++; if (doneFirst != 53) begin failures++; $display("[TB] FAIL b2b_done_cycle got %0d expected 53", doneFirst); end
    mOldX = 8'd120; mOldY = 7'd7; mRot = 2'd0;
  endtask

  task automatic test_reset_mid_draw();
    logic [7:0] tx;
    logic [6:0] ty;
    tx = 8'($urandom_range(0, 155));
    ty = 7'($urandom_range(0, 115));
    sprite = 25'($urandom);
    start = 1'b1; new_x = tx; new_y = ty; new_dir = 2'd1;
    @(negedge clock);
    start = 1'b0;
    repeat (39) @(negedge clock);
    checks++;
    if (vga_plot !== 1'b1 || vga_x !== tx + 8'd2 || vga_y !== ty + 7'd2) begin
      failures++; $display("[TB] FAIL midrst_px12 got plot %b (%0d,%0d) expected plot 1 (%0d,%0d)", vga_plot, vga_x, vga_y, tx + 8'd2, ty + 7'd2);
    end
    resetn = 1'b0;
    @(negedge clock);
    checks++; if (busy !== 1'b0)     begin failures++; $display("[TB] FAIL midrst_busy got %b expected 0", busy); end
    checks++; if (vga_plot !== 1'b0) begin failures++; $display("[TB] FAIL midrst_plot got %b expected 0", vga_plot); end
    checks++; if (rotation !== 2'd0) begin failures++; $display("[TB] FAIL midrst_rotation got %0d expected 0", rotation); end
    resetn = 1'b1;
    @(negedge clock);
    mOldX = 8'd78; mOldY = 7'd58; mRot = 2'd0;
    captureRequest(1'b1, 1'b0, 8'd50, 7'd50, 2'd2, -1, -1);
    checks++; if (pCyc.size() != 50) begin failures++; $display("[TB] FAIL midrst_plot_count got %0d expected 50", pCyc.size()); end
    if (pCyc.size() > 24) begin
      checks++;
      if (pX[0] !== 8'd78 || pY[0] !== 7'd58 || pX[24] !== 8'd82 || pY[24] !== 7'd62) begin
        failures++; $display("[TB] FAIL midrst_erase_pos got (%0d,%0d)..(%0d,%0d) expected (78,58)..(82,62)", pX[0], pY[0], pX[24], pY[24]);
      end
    end
    mOldX = 8'd50; mOldY = 7'd50; mRot = 2'd2;
  endtask

  initial begin
    test_reset();
    test_move();
    test_sprite_pixels();
    test_hide_and_start();
    test_move();
    test_busy_ignored();
    test_back_to_back();
    test_reset_mid_draw();
    test_move();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule
